data_buffer: RTL and testbench
==============================

# data_buffer

Byte-wide 64-entry circular FIFO that holds packet payload between the serial-side byte producer and the AHB-side consumer. Bytes are pushed one at a time. The consumer pops 1, 2 or 4 bytes per request, little-endian. The per-cycle accepted-write strobe `wr_accept` and `flush` drive `w_enable` and `flush` of the 64-byte completion counter directly downstream. Occupancy is reported so the bus side can gate reads.

## Interface
Parameters:
- `DEPTH`, 64: number of byte entries; power of two.
- `DATA_W`, 8: entry width in bits.

Ports:
- `clk`, input, 1: clock.
- `n_rst`, input, 1: reset, asynchronous, active-low.
- `flush`, input, 1: synchronous clear of contents and pointers.
- `push`, input, 1: write request for `wr_data`.
- `wr_data`, input, 8: byte to store.
- `pop`, input, 1: read request.
- `pop_size`, input, 2: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes; 11 is reserved and treated as a rejected pop.
- `wr_accept`, output, 1: push accepted this cycle (combinational); feeds the counter's `w_enable`.
- `rd_accept`, output, 1: pop accepted this cycle (combinational).
- `rd_data`, output, 32: registered popped bytes; byte 0 in [7:0]; unused upper bytes are zero.
- `rd_valid`, output, 1: `rd_data` is valid; one-cycle pulse.
- `occupancy`, output, 7: stored byte count, 0 to 64.
- `full`, output, 1: `occupancy` == 64.
- `empty`, output, 1: `occupancy` == 0.

## Operation
- **Storage:** 64 x 8 register array. Pointers `wptr` and `rptr` are 6 bits wide and wrap modulo 64. `occupancy` is held in a 7-bit register.
- **Push:** `wr_accept` = `push` & !`flush` & (`occupancy` < 64).
  - On accept: `mem[wptr]` <= `wr_data` and `wptr` increments.
  - A push while full is dropped silently, with no state change.
- **Pop:** let n = 1, 2 or 4 from `pop_size`.
  - `rd_accept` = `pop` & !`flush` & `pop_size` != 11 & (`occupancy` >= n).
  - On accept: `rd_data` <= {zero-fill, `mem[rptr+n-1]` ... `mem[rptr]`}, with index arithmetic mod 64 so reads may straddle the wrap point. Then `rptr` += n and `rd_valid` is set for the next cycle.
  - A rejected pop leaves all state unchanged and `rd_valid` is 0 next cycle.
- **Occupancy and thresholds:**
  - Next `occupancy` = `occupancy` + `wr_accept` − (`rd_accept` ? n : 0).
  - Accept decisions use the pre-cycle `occupancy` only:
    - A byte pushed in cycle t is not poppable until t+1.
    - A push while full is rejected even if a pop is accepted in the same cycle.
- **Flush:** has priority over push and pop.
  - Next cycle: `wptr` = `rptr` = 0, `occupancy` = 0, `rd_valid` = 0.
  - `rd_data` holds its value.
  - Memory contents are don't-care.
- **Reset:** `wptr` = `rptr` = 0, `occupancy` = 0, `rd_data` = 0, `rd_valid` = 0, `full` = 0, `empty` = 1.
- **No FSM:** the pointers and `occupancy` are the entire control state.

## Timing
- Push to `occupancy`/`full`/`empty` update: 1 cycle.
- Pop to `rd_data`/`rd_valid`: 1 cycle. Back-to-back pops every cycle are supported.
- `wr_accept` and `rd_accept` are combinational from inputs and current state. They carry no dependency on each other, so there is no loop.
- `full` and `empty` decode registered `occupancy`, so they are glitch-free.
- Downstream counter: 64 accepted pushes after a flush produce its done flag one cycle after the 64th `wr_accept`, coincident with `full` = 1.
- Reset asserted mid-transfer: all outputs take reset values immediately (asynchronously). Any in-flight `rd_valid` is cancelled.

## Structure
- Shared package `data_buffer_pkg` holds:
  - localparams `BUF_DEPTH` = 64, `PTR_W` = 6, `OCC_W` = 7.
  - typedef enum `pop_size_t` {`POP_1B`, `POP_2B`, `POP_4B`, `POP_RSVD`}.
  - function `pop_bytes(pop_size_t)` returning 0, 1, 2 or 4.
- One sub-module, `fifo_ptr_ctrl`. It owns `wptr`, `rptr`, `occupancy`, the accept logic and flush. It exports the pointers to the top, which contains the memory array and read-data muxing.

## Test plan
- **Reset, then fill:** reset, then 64 pushes of 0x00..0x3F → `occupancy` 64, `full` = 1. A 65th push gives `wr_accept` = 0 and `occupancy` stays 64.
- **4-byte pop:** pop 4 bytes from the full buffer → next cycle `rd_data` = 0x03020100, `rd_valid` = 1, `occupancy` 60.
- **Wrap straddle:** reach `rptr` = 62 with 4 bytes stored (values A0, A1, B0, B1, wrapping to `wptr` = 2). Pop 4 bytes → `rd_data` = 0xB1B0A1A0.
- **Underflow:** with `occupancy` 1, pop 2 bytes → `rd_accept` = 0, `rd_valid` = 0, `occupancy` 1. Then pop 1 byte → correct byte, zero-filled upper bits.
- **Simultaneous events:**
  - At `occupancy` 10, push + pop(2) in one cycle → `occupancy` 9.
  - At `occupancy` 64, push + pop(1) → push rejected, `occupancy` 63.
  - At `occupancy` 0, push + pop(1) → pop rejected, `occupancy` 1.
- **Flush:** at `occupancy` 30, assert `flush` with `push` = 1 → `wr_accept` = 0 and `occupancy` = 0, `empty` = 1 next cycle. Then assert `n_rst` low mid-pop → `rd_valid` = 0 and `rd_data` = 0 immediately.

Source files
------------

// File: rtl/data_buffer_pkg.sv
// data_buffer_pkg: shared sizing constants, pop-size encoding and the
// helper that turns a pop-size code into a byte count.
// Used by: data_buffer (top) and fifo_ptr_ctrl (pointer/occupancy control).
package data_buffer_pkg;

   localparam int BUF_DEPTH = 64;
   localparam int PTR_W     = 6;
   localparam int OCC_W     = 7;

   // Occupancy value meaning "every entry holds a byte".
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);

   typedef enum logic [1:0] {
      POP_1B   = 2'b00,
      POP_2B   = 2'b01,
      POP_4B   = 2'b10,
      POP_RSVD = 2'b11
   } pop_size_t;

   // Zero for the reserved code, so callers can treat "0 bytes" as reject.
   function automatic logic [2:0] pop_bytes(input pop_size_t sz);
      case (sz)
         POP_1B:  return 3'd1;
         POP_2B:  return 3'd2;
         POP_4B:  return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: write/read pointers, occupancy register and accept logic.
// Ports: push/pop/pop_size/flush requests in; wr_accept/rd_accept (comb),
//        wptr/rptr/occupancy (registered) and pop_n (bytes per pop) out.
module fifo_ptr_ctrl
   import data_buffer_pkg::*;
(
   input  logic             clk,
   input  logic             n_rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [1:0]       pop_size,
   output logic             wr_accept,
   output logic             rd_accept,
   output logic [PTR_W-1:0] wptr,
   output logic [PTR_W-1:0] rptr,
   output logic [OCC_W-1:0] occupancy,
   output logic [2:0]       pop_n
);

   logic [OCC_W-1:0] pop_n_occ;

   // Both accepts look only at the registered occupancy, never at each
   // other: a same-cycle pop cannot make room for a push and a same-cycle
   // push cannot supply a pop.
   always_comb begin
      pop_n     = pop_bytes(pop_size_t'(pop_size));
      pop_n_occ = {{(OCC_W-3){1'b0}}, pop_n};
      wr_accept = push & ~flush & (occupancy < OCC_FULL);
      rd_accept = pop & ~flush & (pop_n != 3'd0) & (occupancy >= pop_n_occ);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wptr      <= '0;
         rptr      <= '0;
         occupancy <= '0;
      end else if (flush) begin
         wptr      <= '0;
         rptr      <= '0;
         occupancy <= '0;
      end else begin
         if (wr_accept) wptr <= wptr + PTR_W'(1);
         // Pointers are exactly log2(depth) wide, so wrap is free.
         if (rd_accept) rptr <= rptr + PTR_W'(pop_n);
         occupancy <= occupancy + OCC_W'(wr_accept)
                      - (rd_accept ? pop_n_occ : '0);
      end
   end

endmodule

// File: rtl/data_buffer.sv
// data_buffer: 64 x 8 circular byte FIFO; byte push, 1/2/4-byte LE pop.
// Ports: push/wr_data, pop/pop_size, flush in; wr_accept/rd_accept (comb),
//        rd_data/rd_valid (registered, 1-cycle), occupancy/full/empty out.
module data_buffer
   import data_buffer_pkg::*;
#(
   parameter int DEPTH  = BUF_DEPTH,
   parameter int DATA_W = 8
)(
   input  logic                clk,
   input  logic                n_rst,
   input  logic                flush,
   input  logic                push,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                pop,
   input  logic [1:0]          pop_size,
   output logic                wr_accept,
   output logic                rd_accept,
   output logic [4*DATA_W-1:0] rd_data,
   output logic                rd_valid,
   output logic [OCC_W-1:0]    occupancy,
   output logic                full,
   output logic                empty
);

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]    wptr;
   logic [PTR_W-1:0]    rptr;
   logic [2:0]          pop_n;
   logic [4*DATA_W-1:0] rd_word;

   fifo_ptr_ctrl u_ptr_ctrl (
      .clk       (clk),
      .n_rst     (n_rst),
      .flush     (flush),
      .push      (push),
      .pop       (pop),
      .pop_size  (pop_size),
      .wr_accept (wr_accept),
      .rd_accept (rd_accept),
      .wptr      (wptr),
      .rptr      (rptr),
      .occupancy (occupancy),
      .pop_n     (pop_n)
   );

   // Storage has no reset; contents are only observable behind occupancy.
   always_ff @(posedge clk) begin
      if (wr_accept) mem[wptr] <= wr_data;
   end

   // Gather up to four consecutive entries starting at rptr. The index add
   // is done at pointer width so a read straddling the end wraps to 0.
   // Lanes beyond the requested size stay zero.
   always_comb begin
      rd_word = '0;
      for (int k = 0; k < 4; k++) begin
         if (3'(k) < pop_n) rd_word[k*DATA_W +: DATA_W] = mem[rptr + PTR_W'(k)];
      end
   end

   // rd_accept is already low under flush, so rd_valid drops and rd_data
   // holds across a flush without extra terms.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_accept;
         if (rd_accept) rd_data <= rd_word;
      end
   end

   assign full  = (occupancy == OCC_FULL);
   assign empty = (occupancy == '0);

endmodule

// File: tb/tb_data_buffer.sv
// tb_data_buffer: directed stimulus for data_buffer with a byte-queue model
// and a scoreboard of expected pop words compared when rd_valid appears.
module tb_data_buffer;

   logic        clk;
   logic        n_rst;
   logic        flush;
   logic        push;
   logic [7:0]  wr_data;
   logic        pop;
   logic [1:0]  pop_size;
   logic        wr_accept;
   logic        rd_accept;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic [6:0]  occupancy;
   logic        full;
   logic        empty;

   int total = 0;
   int bad   = 0;

   logic [7:0]  mq[$];     // model contents, oldest first
   logic [31:0] exp_q[$];  // expected rd_data words in pop order

   data_buffer dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .flush     (flush),
      .push      (push),
      .wr_data   (wr_data),
      .pop       (pop),
      .pop_size  (pop_size),
      .wr_accept (wr_accept),
      .rd_accept (rd_accept),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .occupancy (occupancy),
      .full      (full),
      .empty     (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state();
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      chk("full",  32'(full),  32'(mq.size() == 64));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
   endtask

   // One clock: drive at negedge, check accepts, update model, check
   // registered outputs just after the following posedge.
   task automatic cyc(input logic p, input logic [7:0] d, input logic q,
                      input logic [1:0] sz, input logic f);
      logic        wacc;
      logic        racc;
      int          n;
      logic [31:0] w;
      @(negedge clk);
      push = p; wr_data = d; pop = q; pop_size = sz; flush = f;
      n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
      wacc = p && !f && (mq.size() < 64);
      racc = q && !f && (n != 0) && (mq.size() >= n);
      #1;
      chk("wr_accept", 32'(wr_accept), 32'(wacc));
      chk("rd_accept", 32'(rd_accept), 32'(racc));
      if (f) begin
         mq.delete();
      end else begin
         if (racc) begin
            w = '0;
            for (int k = 0; k < n; k++) w[8*k +: 8] = mq.pop_front();
            exp_q.push_back(w);
         end
         if (wacc) mq.push_back(d);
      end
      @(posedge clk);
      #1;
      chk("rd_valid", 32'(rd_valid), 32'(racc));
      if (rd_valid) begin
         if (exp_q.size() > 0) chk("rd_data", rd_data, exp_q.pop_front());
         else chk("sb_underrun", 32'd1, 32'd0);
      end
      chk_state();
   endtask

   initial begin
      n_rst = 1'b0; flush = 1'b0; push = 1'b0; wr_data = '0;
      pop = 1'b0; pop_size = '0;
      #12;
      chk("rst_occ",   32'(occupancy), 32'd0);
      chk("rst_empty", 32'(empty),     32'd1);
      chk("rst_full",  32'(full),      32'd0);
      chk("rst_vld",   32'(rd_valid),  32'd0);
      chk("rst_data",  rd_data,        32'd0);
      @(negedge clk);
      n_rst = 1'b1;

      // Fill 0x00..0x3F, then one push too many.
      for (int i = 0; i < 64; i++) cyc(1'b1, 8'(i), 1'b0, 2'd0, 1'b0);
      chk("fill_occ",  32'(occupancy), 32'd64);
      chk("fill_full", 32'(full),      32'd1);
      cyc(1'b1, 8'hFF, 1'b0, 2'd0, 1'b0);
      chk("ovf_occ", 32'(occupancy), 32'd64);

      // 4-byte pop from full buffer.
      cyc(1'b0, 8'h00, 1'b1, 2'd2, 1'b0);
      chk("pop4_data", rd_data, 32'h03020100);
      chk("pop4_occ",  32'(occupancy), 32'd60);

      // Advance rptr to 62 with bytes 0x3E,0x3F left, add B0,B1 across wrap.
      repeat (14) cyc(1'b0, 8'h00, 1'b1, 2'd2, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 2'd1, 1'b0);
      chk("pre_wrap_occ", 32'(occupancy), 32'd2);
      cyc(1'b1, 8'hB0, 1'b0, 2'd0, 1'b0);
      cyc(1'b1, 8'hB1, 1'b0, 2'd0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 2'd2, 1'b0);
      chk("wrap_data", rd_data, 32'hB1B03F3E);

      // Underflow: 2-byte pop with one byte stored, then 1-byte pop.
      cyc(1'b1, 8'h5A, 1'b0, 2'd0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 2'd1, 1'b0);
      chk("uf_occ", 32'(occupancy), 32'd1);
      cyc(1'b0, 8'h00, 1'b1, 2'd0, 1'b0);
      chk("uf_data", rd_data, 32'h0000005A);

      // Reserved pop size is rejected.
      cyc(1'b1, 8'h11, 1'b0, 2'd0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 2'd3, 1'b0);
      chk("rsvd_occ", 32'(occupancy), 32'd1);
      cyc(1'b0, 8'h00, 1'b1, 2'd0, 1'b0);

      // Simultaneous push and pop at empty, mid-level and full.
      cyc(1'b1, 8'h20, 1'b1, 2'd0, 1'b0);
      chk("sim_empty_occ", 32'(occupancy), 32'd1);
      for (int i = 0; i < 9; i++) cyc(1'b1, 8'h21 + 8'(i), 1'b0, 2'd0, 1'b0);
      cyc(1'b1, 8'h77, 1'b1, 2'd1, 1'b0);
      chk("sim_mid_occ", 32'(occupancy), 32'd9);
      for (int i = 0; i < 55; i++) cyc(1'b1, 8'h80 + 8'(i), 1'b0, 2'd0, 1'b0);
      chk("sim_full_pre", 32'(full), 32'd1);
      cyc(1'b1, 8'h88, 1'b1, 2'd0, 1'b0);
      chk("sim_full_occ", 32'(occupancy), 32'd63);

      // Drain to 30 then flush with a push.
      repeat (8) cyc(1'b0, 8'h00, 1'b1, 2'd2, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 2'd0, 1'b0);
      chk("pre_flush_occ", 32'(occupancy), 32'd30);
      cyc(1'b1, 8'h99, 1'b0, 2'd0, 1'b1);
      chk("flush_occ",   32'(occupancy), 32'd0);
      chk("flush_empty", 32'(empty),     32'd1);

      // Reset in the middle of a pop stream.
      cyc(1'b1, 8'hC0, 1'b0, 2'd0, 1'b0);
      cyc(1'b1, 8'hC1, 1'b0, 2'd0, 1'b0);
      cyc(1'b1, 8'hC2, 1'b0, 2'd0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 2'd1, 1'b0);
      chk("pre_rst_data", rd_data, 32'h0000C1C0);
      @(negedge clk);
      push = 1'b0; pop = 1'b1; pop_size = 2'd0; flush = 1'b0;
      chk("pre_rst_vld", 32'(rd_valid), 32'd1);
      #1;
      n_rst = 1'b0;
      #1;
      chk("arst_vld",   32'(rd_valid),  32'd0);
      chk("arst_data",  rd_data,        32'd0);
      chk("arst_occ",   32'(occupancy), 32'd0);
      chk("arst_empty", 32'(empty),     32'd1);
      mq.delete();
      exp_q.delete();
      pop = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      cyc(1'b1, 8'hE0, 1'b0, 2'd0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 2'd0, 1'b0);
      chk("post_rst_data", rd_data, 32'h000000E0);

      chk("sb_left", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
